// File: rtl/if_fetch_unit.sv
// Instruction-fetch sequencer: owns the PC, fetches WORDS memory words per
// instruction over a request/MFC handshake, assembles them into ir_out and
// presents the result to decode under a valid/ack handshake.
// Optional MFC watchdog: define IF_TIMEOUT_EN to build the WAIT-cycle counter
// and the FAULT exit; without it WAIT waits indefinitely and fault stays 0.
module if_fetch_unit #(
  parameter int unsigned        ADDR_W   = 16,
  parameter int unsigned        DATA_W   = 16,
  parameter int unsigned        WORDS    = 2,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        TIMEOUT  = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      branch_valid,
  input  logic [ADDR_W-1:0]         branch_addr,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_en,
  output logic                      mem_rd,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic                      mfc,
  output logic [DATA_W*WORDS-1:0]   ir_out,
  output logic                      ir_valid,
  input  logic                      ir_ack,
  output logic [ADDR_W-1:0]         pc,
  output logic                      busy,
  output logic                      fault
);

  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;

  // Reject out-of-range configurations at elaboration
  if (WORDS < 1 || WORDS > 8 || TIMEOUT < 1) begin : gBadParams
    $error("if_fetch_unit: WORDS must be 1..8 and TIMEOUT at least 1");
  end

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    DONE,
    FAULT
  } state_t;

  state_t        state;
  logic [KW-1:0] wordIdx;

`ifdef IF_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [TW-1:0] waitCnt;
`endif

  // The memory address is always the program counter
  assign mem_addr = pc;

  // Fetch sequencer; every output is updated alongside the state it belongs to
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      wordIdx  <= '0;
      ir_out   <= '0;
      mem_en   <= 1'b0;
      mem_rd   <= 1'b0;
      ir_valid <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
`ifdef IF_TIMEOUT_EN
      waitCnt  <= '0;
`endif
    end else if (branch_valid) begin
      state    <= IDLE;
      pc       <= branch_addr;
      wordIdx  <= '0;
      mem_en   <= 1'b0;
      mem_rd   <= 1'b0;
      ir_valid <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= ADDR;
            wordIdx <= '0;
            mem_en  <= 1'b1;
            mem_rd  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ADDR: begin
          state <= WAIT;
`ifdef IF_TIMEOUT_EN
          waitCnt <= '0;
`endif
        end
        WAIT: begin
          if (mfc) begin
            ir_out[int'(wordIdx)*DATA_W +: DATA_W] <= mem_data;
            pc <= pc + 1'b1;
            if (wordIdx == KW'(WORDS - 1)) begin
              state    <= DONE;
              mem_en   <= 1'b0;
              mem_rd   <= 1'b0;
              busy     <= 1'b0;
              ir_valid <= 1'b1;
            end else begin
              state   <= ADDR;
              wordIdx <= wordIdx + 1'b1;
            end
          end
`ifdef IF_TIMEOUT_EN
          else if (waitCnt == TW'(TIMEOUT - 1)) begin
            state  <= FAULT;
            mem_en <= 1'b0;
            mem_rd <= 1'b0;
            busy   <= 1'b0;
            fault  <= 1'b1;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
`endif
        end
        DONE: begin
          if (ir_ack) begin
            ir_valid <= 1'b0;
            if (start) begin
              state   <= ADDR;
              wordIdx <= '0;
              mem_en  <= 1'b1;
              mem_rd  <= 1'b1;
              busy    <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: behavioural MFC memory responder, scoreboards for
// issued memory addresses and delivered instructions, directed fetch scenarios.
`timescale 1ns/1ps
module tb_if_fetch_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned NW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              branch_valid;
  logic [AW-1:0]     branch_addr;
  logic [AW-1:0]     mem_addr;
  logic              mem_en;
  logic              mem_rd;
  logic [DW-1:0]     mem_data;
  logic              mfc;
  logic [DW*NW-1:0]  ir_out;
  logic              ir_valid;
  logic              ir_ack;
  logic [AW-1:0]     pc;
  logic              busy;
  logic              fault;

  int vectors     = 0;
  int miscompares = 0;

  logic [AW-1:0]    addrQ[$];
  logic [DW*NW-1:0] irQ[$];

  logic          mfcNever    = 1'b0;
  logic [AW-1:0] delayAddr   = 16'h8000;
  int            delayCycles = 0;

  if_fetch_unit #(
    .ADDR_W   (AW),
    .DATA_W   (DW),
    .WORDS    (NW),
    .RESET_PC (16'h0010),
    .TIMEOUT  (15)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .branch_valid (branch_valid),
    .branch_addr  (branch_addr),
    .mem_addr     (mem_addr),
    .mem_en       (mem_en),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mfc          (mfc),
    .ir_out       (ir_out),
    .ir_valid     (ir_valid),
    .ir_ack       (ir_ack),
    .pc           (pc),
    .busy         (busy),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  // Memory contents seen by the fetch unit
  function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
    if (a == 16'h0010) return 16'hAAAA;
    if (a == 16'h0011) return 16'h5555;
    return a ^ 16'h3C3C;
  endfunction

  // Instruction expected from a fetch starting at address a (word 0 lowest)
  function automatic logic [DW*NW-1:0] expInstr(input logic [AW-1:0] a);
    logic [DW*NW-1:0] r;
    logic [AW-1:0]    wa;
    r = '0;
    for (int i = 0; i < NW; i++) begin
      wa = a + AW'(i);
      r[i*DW +: DW] = memWord(wa);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Memory: mfc rises in the first WAIT cycle of a request, later for delayAddr
  initial begin : responder
    int            c;
    logic          prevEn;
    logic [AW-1:0] prevAddr;
    c = 0; prevEn = 1'b0; prevAddr = '0;
    mfc = 1'b0; mem_data = '0;
    forever begin
      @(negedge clk);
      if (mem_en !== 1'b1) c = 0;
      else if (!prevEn || mem_addr != prevAddr) c = 1;
      else c++;
      prevEn = (mem_en === 1'b1);
      prevAddr = mem_addr;
      if (mem_en === 1'b1 && !mfcNever &&
          c >= 2 + ((mem_addr == delayAddr) ? delayCycles : 0)) begin
        mfc = 1'b1;
        mem_data = memWord(mem_addr);
      end else begin
        mfc = 1'b0;
        mem_data = '0;
      end
    end
  end

  // Each new memory request must match the next expected address
  initial begin : addrMonitor
    logic          prevEn;
    logic [AW-1:0] prevAddr;
    prevEn = 1'b0; prevAddr = '0;
    forever begin
      @(negedge clk);
      if (mem_en === 1'b1 && (!prevEn || mem_addr != prevAddr)) begin
        if (addrQ.size() == 0) check("memAddrUnexpected", 64'(addrQ.size()), 64'd1);
        else check("memAddr", mem_addr, addrQ.pop_front());
      end
      prevEn = (mem_en === 1'b1);
      prevAddr = mem_addr;
    end
  end

  // Each rising ir_valid must deliver the next expected instruction
  initial begin : irMonitor
    logic prevValid;
    prevValid = 1'b0;
    forever begin
      @(negedge clk);
      if (ir_valid === 1'b1 && !prevValid) begin
        if (irQ.size() == 0) check("irOutUnexpected", 64'(irQ.size()), 64'd1);
        else check("irOut", ir_out, irQ.pop_front());
      end
      prevValid = (ir_valid === 1'b1);
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL globalTimeout: simulation did not finish, %0d miscompares so far", miscompares);
    $fatal(1);
  end

  // Drive start (optionally with ir_ack) for one cycle and queue expectations
  task automatic issue(input logic [AW-1:0] a, input int nAddr, input bit complete,
                       input bit withAck);
    for (int i = 0; i < nAddr; i++) addrQ.push_back(a + AW'(i));
    if (complete) irQ.push_back(expInstr(a));
    start = 1'b1;
    ir_ack = withAck;
    @(negedge clk);
    start = 1'b0;
    ir_ack = 1'b0;
  endtask

  // Cycles from the start edge until ir_valid; also flags request gaps while busy
  task automatic waitValid(output int n, output int badEn);
    n = 0;
    badEn = 0;
    while (ir_valid !== 1'b1 && n < 100) begin
      if (busy === 1'b1 && (mem_en !== 1'b1 || mem_rd !== 1'b1)) badEn++;
      @(negedge clk);
      n++;
    end
    if (ir_valid !== 1'b1) check("irValidTimeout", 64'd0, 64'd1);
  endtask

  task automatic ackNow();
    ir_ack = 1'b1;
    @(negedge clk);
    ir_ack = 1'b0;
  endtask

  initial begin : main
    int n;
    int bad;
    reset = 1'b1; start = 1'b0; branch_valid = 1'b0; branch_addr = '0; ir_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("resetPc", pc, 16'h0010);
    check("resetMemAddr", mem_addr, 16'h0010);
    check("resetMemEn", mem_en, 1'b0);
    check("resetMemRd", mem_rd, 1'b0);
    check("resetIrValid", ir_valid, 1'b0);
    check("resetBusy", busy, 1'b0);
    check("resetFault", fault, 1'b0);
    check("resetIrOut", ir_out, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // Basic two-word fetch, MFC in the first WAIT cycle
    issue(16'h0010, 2, 1'b1, 1'b0);
    check("busyInAddr", busy, 1'b1);
    check("memEnInAddr", mem_en, 1'b1);
    check("memRdInAddr", mem_rd, 1'b1);
    waitValid(n, bad);
    check("latBasic", n, 4);
    check("memEnHeldBasic", bad, 0);
    check("pcAfterBasic", pc, 16'h0012);
    ackNow();
    check("irValidAfterAck", ir_valid, 1'b0);
    check("busyAfterAck", busy, 1'b0);

    // Word 0 answered three cycles late
    delayAddr = 16'h0012; delayCycles = 3;
    issue(16'h0012, 2, 1'b1, 1'b0);
    waitValid(n, bad);
    check("latDelayed", n, 7);
    check("memEnHeldDelayed", bad, 0);
    check("pcAfterDelayed", pc, 16'h0014);
    delayAddr = 16'h8000; delayCycles = 0;

    // start without ir_ack in DONE is ignored
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    check("irValidStartNoAck", ir_valid, 1'b1);
    check("busyStartNoAck", busy, 1'b0);
    check("pcStartNoAck", pc, 16'h0014);

    // ir_ack with start: straight back into ADDR
    issue(16'h0014, 2, 1'b1, 1'b1);
    check("busyBackToBack", busy, 1'b1);
    check("memAddrBackToBack", mem_addr, 16'h0014);
    check("irValidBackToBack", ir_valid, 1'b0);
    waitValid(n, bad);
    check("latBackToBack", n, 4);
    ackNow();

    // Branch during WAIT of word 1 with mfc high the same cycle
    issue(16'h0016, 2, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    branch_valid = 1'b1; branch_addr = 16'h0100;
    @(negedge clk);
    branch_valid = 1'b0;
    check("irValidBranch", ir_valid, 1'b0);
    check("busyBranch", busy, 1'b0);
    check("memEnBranch", mem_en, 1'b0);
    check("pcBranch", pc, 16'h0100);
    check("memAddrBranch", mem_addr, 16'h0100);
    issue(16'h0100, 2, 1'b1, 1'b0);
    waitValid(n, bad);
    check("latAfterBranch", n, 4);
    check("pcAfterBranchFetch", pc, 16'h0102);
    ackNow();

    // Memory never answers
    mfcNever = 1'b1;
    issue(16'h0102, 1, 1'b0, 1'b0);
`ifdef IF_TIMEOUT_EN
    n = 0;
    while (fault !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("faultLatency", n, 16);
    check("faultSet", fault, 1'b1);
    check("memEnFault", mem_en, 1'b0);
    check("busyFault", busy, 1'b0);
    check("pcFault", pc, 16'h0102);
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    check("faultIgnoresStart", fault, 1'b1);
    check("memEnFaultStart", mem_en, 1'b0);
`else
    repeat (30) @(negedge clk);
    check("faultTiedLow", fault, 1'b0);
    check("busyStall", busy, 1'b1);
    check("memEnStall", mem_en, 1'b1);
    check("pcStall", pc, 16'h0102);
`endif
    mfcNever = 1'b0;
    branch_valid = 1'b1; branch_addr = 16'hFFFF;
    @(negedge clk);
    branch_valid = 1'b0;
    check("faultClearedByBranch", fault, 1'b0);
    check("busyAfterStallBranch", busy, 1'b0);
    check("memEnAfterStallBranch", mem_en, 1'b0);
    check("pcBranchTop", pc, 16'hFFFF);

    // PC wraps across the top of the address space
    issue(16'hFFFF, 2, 1'b1, 1'b0);
    waitValid(n, bad);
    check("latWrap", n, 4);
    check("pcWrap", pc, 16'h0001);
    ackNow();

    // Asynchronous reset in the middle of a fetch
    issue(16'h0001, 1, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("asyncResetPc", pc, 16'h0010);
    check("asyncResetMemEn", mem_en, 1'b0);
    check("asyncResetMemRd", mem_rd, 1'b0);
    check("asyncResetBusy", busy, 1'b0);
    check("asyncResetIrOut", ir_out, 32'h0);
    check("asyncResetIrValid", ir_valid, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("memEnAfterReset", mem_en, 1'b0);
    check("pcAfterReset", pc, 16'h0010);

    check("addrQueueDrained", 64'(addrQ.size()), 64'd0);
    check("irQueueDrained", 64'(irQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Parametrised instruction-fetch sequencer for the microcontroller datapath. It owns the program counter and fetches a fixed number of memory words per instruction through a request/MFC memory handshake. It assembles the words into a wide instruction register and holds it under a valid/ack handshake for the decode stage. Branch redirects abort any fetch in flight, and an optional MFC watchdog reports a hung memory.

## Interface
- ADDR_W, 16, program-counter / memory address width
- DATA_W, 16, memory word width
- WORDS, 2, memory words per instruction (1..8)
- RESET_PC, 0, PC value after reset
- TIMEOUT, 15, maximum WAIT cycles without MFC before fault (only with IF_TIMEOUT_EN)

- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  request fetch of next instruction
- branch_valid  in  1  redirect PC, abort current fetch
- branch_addr  in  ADDR_W  redirect target
- mem_addr  out  ADDR_W  memory address (= pc)
- mem_en  out  1  memory request
- mem_rd  out  1  read strobe; 1 whenever mem_en=1
- mem_data  in  DATA_W  read data, valid while mfc=1
- mfc  in  1  memory function complete
- ir_out  out  DATA_W*WORDS  assembled instruction; word k at bits [k*DATA_W +: DATA_W]; word 0 is lowest address
- ir_valid  out  1  ir_out holds a complete instruction
- ir_ack  in  1  consumer accepts ir_out
- pc  out  ADDR_W  current program counter
- busy  out  1  state is ADDR or WAIT
- fault  out  1  MFC watchdog expired

## Operation
- States: IDLE, ADDR, WAIT, DONE, FAULT. Internal word index k counts 0..WORDS-1.
- All outputs are registered (Moore).
- Reset values:
  - state IDLE, pc=RESET_PC, k=0, ir_out=0.
  - mem_en=mem_rd=ir_valid=busy=fault=0.
  - mem_addr equals pc, i.e. RESET_PC.
- IDLE: start=1 -> ADDR with k=0.
- ADDR: mem_en=mem_rd=1, mem_addr=pc. Go to WAIT unconditionally. mfc is ignored in ADDR.
- WAIT: mem_en=mem_rd=1.
  - mfc=1: latch mem_data into word k and set pc<=pc+1 (wraps mod 2^ADDR_W).
  - If k<WORDS-1: k<=k+1, go to ADDR. Otherwise go to DONE.
- DONE: ir_valid=1, ir_out stable.
  - ir_ack=1 -> IDLE.
  - ir_ack=1 and start=1 in the same cycle -> ADDR directly (back-to-back fetch).
  - start without ir_ack is ignored.
- Branch: branch_valid=1 in any state has highest priority.
  - pc<=branch_addr, k<=0, next state IDLE.
  - ir_valid drops, words already captured are discarded, a same-cycle mfc is ignored, and fault clears.
- FAULT: mem_en=0, fault=1, pc holds the faulting word's address. start is ignored. Only branch_valid or reset exits.

## Timing
- start sampled at edge E0 -> ADDR during E0..E1, WAIT from E1.
- Minimum 2 cycles per word (MFC high in the first WAIT cycle).
- ir_valid rises at edge E(2*WORDS) at best; each extra WAIT cycle adds 1.
- pc updates on the same edge that captures the word.
- ir_ack is honoured on the first DONE cycle, so ir_valid can be a single-cycle pulse.
- Asynchronous reset mid-fetch forces reset values immediately. Partial words are lost and no memory request persists.

## Configuration
- IF_TIMEOUT_EN defined:
  - A WAIT cycle counter clears on every ADDR->WAIT transition and increments each WAIT cycle with mfc=0.
  - When the counter reaches TIMEOUT with mfc still 0, the next state is FAULT.
  - mfc=1 in the same cycle the counter reaches TIMEOUT wins: normal capture, no fault.
- IF_TIMEOUT_EN undefined: WAIT persists indefinitely, FAULT is unreachable, fault is tied 0, and no counter is built.

## Test plan
- Reset, WORDS=2, RESET_PC=0x0010, start pulse, mfc in first WAIT with data 0xAAAA then 0x5555 -> ir_out=0x5555AAAA, ir_valid at start+4 edges, pc=0x0012, mem_addr sequence 0x0010, 0x0011.
- MFC delayed 3 cycles on word 0 -> mem_en held high throughout, ir_valid at start+7, data correct.
- branch_valid with branch_addr=0x0100 during WAIT of word 1, with mfc high the same cycle -> state IDLE, ir_valid=0, pc=0x0100. The next fetch reads from 0x0100.
- DONE with ir_ack=1 and start=1 together -> ADDR the next cycle, mem_addr=pc (0x0012), no idle cycle.
- IF_TIMEOUT_EN, TIMEOUT=15, mfc never asserted -> fault=1 and mem_en=0 after 15 WAIT cycles, pc unchanged. A branch clears fault.
- pc=0xFFFF, WORDS=1, single fetch -> pc wraps to 0x0000.
